// File: rtl/mux_tristate.sv
// 2:1 mux built from two complementary tristate drivers on an internal net,
// plus a clocked observation stage (registered Y, registered sel, sel-change count).
module mux_tristate #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_changes
);

    // Shared net needs net semantics to accept two resolved drivers.
    wire logic [WIDTH-1:0] bus;

    assign bus = (sel == 1'b0) ? d0 : 'z;
    assign bus = (sel == 1'b1) ? d1 : 'z;

    assign Y = bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            sel_q       <= 1'b0;
            sel_changes <= '0;
        end else begin
            y_q   <= bus;
            sel_q <= sel;
            if ((sel != sel_q) && (sel_changes != '1)) begin
                sel_changes <= sel_changes + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_tristate.sv
// Directed self-checking bench for mux_tristate (WIDTH=1 and WIDTH=8 instances).
module tb_mux_tristate;

    logic       clk;
    logic       rst_n;
    logic       d0, d1, sel;
    logic       y, y_q, sel_q;
    logic [7:0] sel_changes;

    logic [7:0] d0_8, d1_8;
    logic       sel8;
    logic [7:0] y8, y_q8;
    logic       sel_q8;
    logic [7:0] sel_changes8;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mux_tristate #(.WIDTH(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .sel(sel),
        .Y(y), .y_q(y_q), .sel_q(sel_q), .sel_changes(sel_changes)
    );

    mux_tristate #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .d0(d0_8), .d1(d1_8), .sel(sel8),
        .Y(y8), .y_q(y_q8), .sel_q(sel_q8), .sel_changes(sel_changes8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        logic [7:0] y_table;
        logic [2:0] vec;
        y_table = 8'b1101_1000;   // bit i = expected Y for {d0,d1,sel}=i
        rst_n = 1'b0;
        d0 = 1'b0; d1 = 1'b0; sel = 1'b0;
        d0_8 = 8'hA5; d1_8 = 8'h3C; sel8 = 1'b0;
        #1;
        check("rst y_q", 32'(y_q), 32'd0);
        check("rst sel_q", 32'(sel_q), 32'd0);
        check("rst cnt", 32'(sel_changes), 32'd0);

        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {d0, d1, sel} = vec;
            #1;
            check($sformatf("comb %0d", i), 32'(y), 32'(y_table[i]));
        end

        sel8 = 1'b0; #1;
        check("w8 sel0 Y", 32'(y8), 32'hA5);
        sel8 = 1'b1; #1;
        check("w8 sel1 Y", 32'(y8), 32'h3C);

        // Registered path
        @(negedge clk);
        rst_n = 1'b1;
        d0 = 1'b1; d1 = 1'b0; sel = 1'b0;
        @(posedge clk); #1;
        check("reg1 y_q", 32'(y_q), 32'd1);
        check("reg1 sel_q", 32'(sel_q), 32'd0);
        check("reg1 cnt", 32'(sel_changes), 32'd0);
        check("w8 y_q 3C", 32'(y_q8), 32'h3C);
        check("w8 cnt first edge", 32'(sel_changes8), 32'd1);

        @(negedge clk);
        sel = 1'b1; sel8 = 1'b0;
        @(posedge clk); #1;
        check("reg2 y_q", 32'(y_q), 32'd0);
        check("reg2 sel_q", 32'(sel_q), 32'd1);
        check("reg2 cnt", 32'(sel_changes), 32'd1);
        check("w8 y_q A5", 32'(y_q8), 32'hA5);

        // Counter: toggle every cycle; count started at 1
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            sel = ~sel;
            @(posedge clk); #1;
            if (i == 100) check("cnt at 100", 32'(sel_changes), 32'd101);
            if (i == 254) check("cnt hits 255", 32'(sel_changes), 32'd255);
        end
        check("cnt saturated", 32'(sel_changes), 32'd255);

        // Reset mid-operation with count 5 and y_q 1
        @(negedge clk);
        rst_n = 1'b0; #1; rst_n = 1'b1;
        d0 = 1'b1; d1 = 1'b1; sel = 1'b0;
        check("pulse clears cnt", 32'(sel_changes), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel = ~sel;
            @(posedge clk); #1;
        end
        check("pre cnt 5", 32'(sel_changes), 32'd5);
        check("pre y_q 1", 32'(y_q), 32'd1);

        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid y_q", 32'(y_q), 32'd0);
        check("mid sel_q", 32'(sel_q), 32'd0);
        check("mid cnt", 32'(sel_changes), 32'd0);
        d0 = 1'b0; d1 = 1'b1; sel = 1'b0; #0.5;
        check("mid Y d0", 32'(y), 32'd0);
        sel = 1'b1; #0.5;
        check("mid Y d1", 32'(y), 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("resume cnt", 32'(sel_changes), 32'd1);
        check("resume y_q", 32'(y_q), 32'd1);
        check("resume sel_q", 32'(sel_q), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
